dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter that shares the single-port 64-bit data memory between the processor core's load/store path (port 0) and the program-loader/debug port (port 1). It sits between the PROCESSOR datapath and the data memory. It allows one outstanding transaction at a time, waits out a fixed memory read latency, and returns a registered completion pulse and read data to the winning requester.

## Interface

Parameters:
- ADDR_W, 10: word-address width.
- MEM_LAT, 1: memory read latency in cycles from `mem_en` to valid `mem_rdata`. Legal range is 1 to 15.

Ports (N = 0 for core, 1 for loader):
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- reqN  in  1  request; held high with fields stable until `gntN` is seen.
- weN  in  1  1 = write, 0 = read.
- addrN  in  ADDR_W  word address.
- wdataN  in  64  write data.
- wstrbN  in  8  byte write enables.
- gntN  out  1  grant; combinational, high in the issue cycle.
- doneN  out  1  one-cycle completion pulse, registered.
- rdataN  out  64  read data, registered; valid while `doneN` is high for reads.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  64  memory write data.
- mem_wstrb  out  8  memory byte strobes.
- mem_rdata  in  64  memory read data, valid MEM_LAT cycles after `mem_en`.

## Operation

- The FSM has two states: IDLE and WAIT.
- **IDLE**
  - If no request is pending, no change.
  - If exactly one request is pending, that port wins.
  - If both are pending, the port that did not win last wins.
  - On a win, in the same cycle: `gntN` = 1 and `mem_en` = 1. `mem_we`, `mem_addr`, `mem_wdata` and `mem_wstrb` are muxed from the winner, and write strobes are forced to 0 for reads.
  - At the clock edge: latch the winner into `owner` and `last`, latch `we` into `op_we`, load `cnt` = MEM_LAT-1, and go to WAIT.
- **WAIT**
  - No grants. `mem_en` = 0. All other memory outputs are 0.
  - If `cnt` != 0, decrement.
  - If `cnt` == 0 (the data-valid cycle): at the edge, if `op_we` = 0, register `mem_rdata` into `rdata[owner]`. Set `done[owner]` for the next cycle and go to IDLE.
- `doneN` is high for exactly the one IDLE cycle after WAIT ends. A new grant can happen in that same cycle, for either port.
- On a write completion, `rdataN` keeps its previous value.
- A `reqN` that drops before grant is ignored. The arbiter never queues requests.
- Memory outputs are 0 whenever `mem_en` = 0.

## Timing

- **Reset (`reset` = 0, asynchronous):**
  - State goes to IDLE, `cnt` = 0, `owner` = 0.
  - `last` = 1, so the core has priority first.
  - `done0`, `done1` = 0; `rdata0`, `rdata1` = 0.
  - `gnt0`, `gnt1` and all memory outputs read 0 while reset is low.
- **Reset mid-transaction:** the transaction is dropped and no `done` is issued. The requester must re-request.
- **Latency:** grant in cycle T, `mem_rdata` sampled at the end of cycle T+MEM_LAT, `doneN` and `rdataN` valid in cycle T+MEM_LAT+1.
- **Throughput:** one transaction per MEM_LAT+1 cycles.
- **Fairness:** a port whose request is held is granted within at most one other transaction.
- **Simultaneous events:** a `reqN` arriving in the same cycle as `doneN` from the previous transaction is arbitrated normally that cycle.
- **Back-to-back requests from the same port:** the request is re-granted only if the other port is not requesting.
- **`cnt` width:** 4 bits. MEM_LAT = 1 means WAIT lasts exactly one cycle.

## Test plan

- **Reset values:** hold `reset` = 0 and assert both requests. Expect all outputs 0. Release reset; in the first IDLE cycle expect `gnt0` = 1 and `gnt1` = 0.
- **Single read, MEM_LAT = 1:** core reads addr 0x004; memory returns 0xDEADBEEF_CAFEF00D one cycle after `mem_en`. Expect `gnt0` at T, `done0` at T+2 with `rdata0` = 0xDEADBEEF_CAFEF00D, and `done1` never high.
- **Contention:** both ports hold reads continuously. Grants alternate 0,1,0,1 with a spacing of 2 cycles, and each `done` goes to the matching port.
- **Write with strobes:** loader writes 0x11223344_55667788 to addr 0x3FF with `wstrb1` = 0x0F. Expect `mem_we` = 1, `mem_wstrb` = 0x0F and `mem_addr` = 0x3FF for exactly one cycle. Expect `done1` at T+2 and `rdata1` unchanged.
- **MEM_LAT = 3:** core read granted at T. Expect `mem_rdata` to be sampled at the end of T+3, `done0` at T+4, and no grant during T+1 through T+3 even though `req1` is high.
- **Reset mid-op:** pull `reset` low during WAIT. Expect no `done` pulse. After release, a held `req1` is granted only if `req0` is low, because priority is back to the core.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port 64-bit data memory between the core (port 0)
// and the loader/debug port (port 1); one transaction in flight, fixed read latency.
module dmem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [63:0]       wdata0,
  input  logic [7:0]        wstrb0,
  output logic              gnt0,
  output logic              done0,
  output logic [63:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [63:0]       wdata1,
  input  logic [7:0]        wstrb1,
  output logic              gnt1,
  output logic              done1,
  output logic [63:0]       rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic [63:0]       mem_rdata,
  output logic              fsm_state
);

  // Handshake: a requester holds reqN with stable fields; the transfer happens in the
  // cycle where reqN && gntN, and completes with a one-cycle doneN pulse MEM_LAT+1 later.
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       last;
  logic       op_we;
  logic       win;
  logic       pick;

  // reset gates the win so grants and memory outputs stay low while reset is held
  always_comb begin
    win  = 1'b0;
    pick = 1'b0;
    if (reset && state == IDLE) begin
      if (req0 && req1) begin
        win  = 1'b1;
        pick = ~last;
      end else if (req0) begin
        win  = 1'b1;
        pick = 1'b0;
      end else if (req1) begin
        win  = 1'b1;
        pick = 1'b1;
      end
    end
  end

  always_comb begin
    gnt0      = win & ~pick;
    gnt1      = win & pick;
    mem_en    = win;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (win) begin
      if (pick) begin
        mem_we    = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_wstrb = we1 ? wstrb1 : 8'h00;
      end else begin
        mem_we    = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_wstrb = we0 ? wstrb0 : 8'h00;
      end
    end
  end

  assign fsm_state = (state == WAIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      owner  <= 1'b0;
      last   <= 1'b1;
      op_we  <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      rdata0 <= 64'd0;
      rdata1 <= 64'd0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (win) begin
            owner <= pick;
            last  <= pick;
            op_we <= pick ? we1 : we0;
            cnt   <= 4'(MEM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // cnt == 0 marks the cycle in which mem_rdata is valid
            if (!op_we) begin
              if (owner) rdata1 <= mem_rdata;
              else       rdata0 <= mem_rdata;
            end
            if (owner) done1 <= 1'b1;
            else       done0 <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two instances (MEM_LAT 1 and 3), each with a memory
// model, a random two-port driver, mid-run reset, and a cycle-level reference model.
module tb_dmem_arbiter;
  localparam int ADDR_W = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input int lat, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL L%0d %s: got %0h expected %0h at %0t", lat, name, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : inst
    localparam int LAT = (k == 0) ? 1 : 3;

    logic              reset;
    logic [1:0]        req, we, gnt, done;
    logic [ADDR_W-1:0] addr [2];
    logic [63:0]       wdata [2];
    logic [7:0]        wstrb [2];
    logic [63:0]       rdata [2];
    logic              mem_en, mem_we, fsm_state;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata, mem_rdata;
    logic [7:0]        mem_wstrb;
    logic              fin = 1'b0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) u_dut (
      .clock(clock), .reset(reset),
      .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .wstrb0(wstrb[0]),
      .gnt0(gnt[0]), .done0(done[0]), .rdata0(rdata[0]),
      .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .wstrb1(wstrb[1]),
      .gnt1(gnt[1]), .done1(done[1]), .rdata1(rdata[1]),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
    );

    // memory environment: read data appears LAT cycles after mem_en, garbage otherwise
    logic [63:0] mem [1024];
    logic [63:0] ref_mem [1024];
    logic [63:0] pipe [LAT];
    assign mem_rdata = pipe[LAT-1];

    initial begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]     = {$urandom, $urandom};
        ref_mem[i] = mem[i];
      end
      mem[4]     = 64'hDEADBEEF_CAFEF00D;
      ref_mem[4] = 64'hDEADBEEF_CAFEF00D;
    end

    always @(posedge clock) begin
      if (mem_en && mem_we)
        for (int b = 0; b < 8; b++)
          if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : {$urandom, $urandom};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    task automatic new_req(input int p);
      req[p]   = 1'b1;
      we[p]    = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       addr[p] = 10'h004;
        1:       addr[p] = 10'h3FF;
        2:       addr[p] = ADDR_W'($urandom_range(0, 7));
        default: addr[p] = ADDR_W'($urandom);
      endcase
      wdata[p] = {$urandom, $urandom};
      wstrb[p] = ($urandom_range(0, 3) == 0) ? 8'h0F : 8'($urandom);
    endtask

    // driver: both ports start requesting reads, then re-request randomly after grants
    initial begin
      logic [1:0] g;
      req      = 2'b11;
      we       = 2'b00;
      addr[0]  = 10'h004;
      addr[1]  = 10'h3FF;
      wdata[0] = 64'd0;
      wdata[1] = 64'd0;
      wstrb[0] = 8'hFF;
      wstrb[1] = 8'hFF;
      forever begin
        @(negedge clock);
        g = gnt;
        @(posedge clock);
        #1;
        for (int p = 0; p < 2; p++) begin
          if (req[p] && g[p]) begin
            if ($urandom_range(0, 3) != 0) new_req(p);
            else req[p] = 1'b0;
          end else if (req[p]) begin
            if ($urandom_range(0, 49) == 0) req[p] = 1'b0;
          end else if ($urandom_range(0, 1) == 0) begin
            new_req(p);
          end
        end
      end
    end

    // reference model state
    logic [63:0] exp_q [$];
    int          port_q [$];
    int          due_q [$];
    logic [63:0] exp_rd [2];
    int          busy_m = 0;
    int          last_m = 1;
    int          cyc = 0;

    // monitor: compares every cycle on the falling edge, then advances the model
    initial begin
      int         win;
      logic [1:0] exp_gnt, exp_done;
      exp_rd[0] = 64'd0;
      exp_rd[1] = 64'd0;
      forever begin
        @(negedge clock);
        cyc++;
        if (!reset) begin
          check(LAT, "rst_gnt", {62'd0, gnt}, 64'd0);
          check(LAT, "rst_mem_en", {63'd0, mem_en}, 64'd0);
          check(LAT, "rst_mem_we", {63'd0, mem_we}, 64'd0);
          check(LAT, "rst_mem_addr", {54'd0, mem_addr}, 64'd0);
          check(LAT, "rst_mem_wdata", mem_wdata, 64'd0);
          check(LAT, "rst_mem_wstrb", {56'd0, mem_wstrb}, 64'd0);
          check(LAT, "rst_done", {62'd0, done}, 64'd0);
          check(LAT, "rst_rdata0", rdata[0], 64'd0);
          check(LAT, "rst_rdata1", rdata[1], 64'd0);
          busy_m    = 0;
          last_m    = 1;
          exp_rd[0] = 64'd0;
          exp_rd[1] = 64'd0;
          exp_q.delete();
          port_q.delete();
          due_q.delete();
        end else begin
          win = -1;
          if (busy_m == 0) begin
            if (req[0] && req[1]) win = 1 - last_m;
            else if (req[0])      win = 0;
            else if (req[1])      win = 1;
          end
          check(LAT, "busy", {63'd0, fsm_state}, {63'd0, busy_m != 0});
          exp_gnt = (win < 0) ? 2'b00 : (win == 0 ? 2'b01 : 2'b10);
          check(LAT, "gnt", {62'd0, gnt}, {62'd0, exp_gnt});
          if (win >= 0) begin
            check(LAT, "mem_en", {63'd0, mem_en}, 64'd1);
            check(LAT, "mem_we", {63'd0, mem_we}, {63'd0, we[win]});
            check(LAT, "mem_addr", {54'd0, mem_addr}, {54'd0, addr[win]});
            check(LAT, "mem_wdata", mem_wdata, wdata[win]);
            check(LAT, "mem_wstrb", {56'd0, mem_wstrb}, {56'd0, we[win] ? wstrb[win] : 8'h00});
          end else begin
            check(LAT, "idle_mem", {mem_en, mem_we, mem_addr, mem_wstrb} | {46'd0, mem_wdata != 64'd0},
                  64'd0);
          end
          exp_done = 2'b00;
          if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_done[port_q[0]] = 1'b1;
            exp_rd[port_q[0]]   = exp_q[0];
            void'(exp_q.pop_front());
            void'(port_q.pop_front());
            void'(due_q.pop_front());
          end
          check(LAT, "done", {62'd0, done}, {62'd0, exp_done});
          check(LAT, "rdata0", rdata[0], exp_rd[0]);
          check(LAT, "rdata1", rdata[1], exp_rd[1]);
          if (win >= 0) begin
            last_m = win;
            busy_m = LAT;
            due_q.push_back(cyc + LAT + 1);
            port_q.push_back(win);
            if (we[win]) begin
              for (int b = 0; b < 8; b++)
                if (wstrb[win][b]) ref_mem[addr[win]][b*8 +: 8] = wdata[win][b*8 +: 8];
              exp_q.push_back(exp_rd[win]);
            end else begin
              exp_q.push_back(ref_mem[addr[win]]);
            end
          end else if (busy_m > 0) begin
            busy_m--;
          end
        end
      end
    end

    // reset sequencing: initial reset with both requests held, then one reset during WAIT
    initial begin
      int n;
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      repeat (300) @(posedge clock);
      #2;
      n = 0;
      while (busy_m == 0 && n < 50) begin
        @(posedge clock);
        #2;
        n++;
      end
      check(LAT, "found_wait", {63'd0, busy_m != 0}, 64'd1);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset = 1'b1;
      repeat (300) @(posedge clock);
      fin = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(inst[0].fin && inst[1].fin) && n < 2000) begin
      @(posedge clock);
      n++;
    end
    check(0, "finished", {63'd0, inst[0].fin && inst[1].fin}, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
